// File: rtl/hazard_forward_unit.sv
// Load-use hazard detection, multi-cycle stall FSM and registered operand forwarding for the ID stage.
// Optional macro HAZARD_ZERO_REG_EN: register specifier 0 is hardwired zero and never matches.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 2,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic                          ex_valid,
    input  logic                          ex_reg_write,
    input  logic                          ex_mem_read,
    input  logic [REG_ADDR_W-1:0]         ex_rd,
    input  logic                          mem_reg_write,
    input  logic [REG_ADDR_W-1:0]         mem_rd,
    input  logic                          flush,
    output logic [NUM_SRC*2-1:0]          fwd_sel,
    output logic                          stall,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int DC_W = (LOAD_LAT > 2) ? $clog2(LOAD_LAT) : 1;
    localparam logic [DC_W-1:0] DC_INIT = (LOAD_LAT > 1) ? DC_W'(LOAD_LAT - 2) : {DC_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t                  state_r;
    logic [DC_W-1:0]         down_cnt_r;
    logic [NUM_SRC*2-1:0]    fwd_sel_r;
    logic [CNT_W-1:0]        stall_cnt_r;
    logic                    hazard_s;
    logic                    stall_s;
    logic [NUM_SRC*2-1:0]    next_sel_s;

    function automatic logic addr_match(input logic [REG_ADDR_W-1:0] a,
                                        input logic [REG_ADDR_W-1:0] b);
`ifdef HAZARD_ZERO_REG_EN
        return (a == b) && (a != {REG_ADDR_W{1'b0}});
`else
        return (a == b);
`endif
    endfunction

    // Hazard detection and next forward selects; EX/MEM wins over MEM/WB.
    always_comb begin
        hazard_s   = 1'b0;
        next_sel_s = {NUM_SRC*2{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_valid && id_src_used[i]) begin
                if (ex_valid && ex_mem_read && ex_reg_write &&
                    addr_match(id_src_addr[i*REG_ADDR_W +: REG_ADDR_W], ex_rd)) begin
                    hazard_s = 1'b1;
                end else begin
                    hazard_s = hazard_s;
                end
                if (ex_reg_write && addr_match(id_src_addr[i*REG_ADDR_W +: REG_ADDR_W], ex_rd)) begin
                    next_sel_s[i*2 +: 2] = 2'b10;
                end else if (mem_reg_write &&
                             addr_match(id_src_addr[i*REG_ADDR_W +: REG_ADDR_W], mem_rd)) begin
                    next_sel_s[i*2 +: 2] = 2'b01;
                end else begin
                    next_sel_s[i*2 +: 2] = 2'b00;
                end
            end else begin
                next_sel_s[i*2 +: 2] = 2'b00;
            end
        end
    end

    // Stall is Mealy: asserted in the hazard cycle itself, always killed by flush or reset.
    always_comb begin
        stall_s = 1'b0;
        if (!reset_n || flush) begin
            stall_s = 1'b0;
        end else if (state_r == ST_STALL) begin
            stall_s = 1'b1;
        end else begin
            stall_s = hazard_s;
        end
    end

    // Stall FSM with down-counter for the remaining LOAD_LAT-1 cycles, plus forward-select register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            down_cnt_r <= {DC_W{1'b0}};
            fwd_sel_r  <= {NUM_SRC*2{1'b0}};
        end else if (flush) begin
            state_r    <= ST_IDLE;
            down_cnt_r <= {DC_W{1'b0}};
            fwd_sel_r  <= {NUM_SRC*2{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hazard_s && (LOAD_LAT > 1)) begin
                        state_r    <= ST_STALL;
                        down_cnt_r <= DC_INIT;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_STALL: begin
                    if (down_cnt_r == {DC_W{1'b0}}) begin
                        state_r    <= ST_IDLE;
                    end else begin
                        down_cnt_r <= down_cnt_r - {{(DC_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    down_cnt_r <= {DC_W{1'b0}};
                end
            endcase
            if (!stall_s) begin
                fwd_sel_r <= next_sel_s;
            end
        end
    end

    // Saturating count of stalled cycles, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign fwd_sel   = fwd_sel_r;
    assign stall     = stall_s;
    assign stall_cnt = stall_cnt_r;

endmodule
